// File: rtl/update_unpacker.sv
// update_unpacker: splits 512-bit packed update words (8 x 64-bit entries)
// into left-compacted beats of up to four 64-bit lanes. This is the inverse
// of the update-buffer packer.
module update_unpacker #(
  parameter int CNT_W = 32,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      update_entry_count,
  input  logic [511:0]          word_in,
  input  logic                  word_in_valid,
  output logic                  word_in_ready,
  output logic [64*LANES-1:0]   entry_out,
  output logic [LANES-1:0]      entry_out_valid,
  input  logic                  entry_out_ready,
  output logic                  last_out,
  output logic                  done,
  output logic [CNT_W-1:0]      consumed_count
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    unfetched;     // entries not yet covered by an accepted word
  logic [CNT_W-1:0]    unstaged;      // entries not yet loaded into the output register
  logic [511:0]        word_buf;
  logic                buf_full;
  logic                half;          // which 256-bit half of word_buf is staged next
  logic                out_fire;
  logic                out_load;
  logic                word_accept;
  logic [2:0]          n_lanes;
  logic [LANES-1:0]    load_mask;
  logic [64*LANES-1:0] load_entries;
  logic [64*LANES-1:0] half_data;

  // Handshake and buffer-advance decisions for the current cycle.
  always_comb begin
    out_fire      = (entry_out_valid != '0) && entry_out_ready;
    out_load      = (state == RUN) && buf_full && ((entry_out_valid == '0) || out_fire);
    // The second half leaving the buffer frees it in the same cycle, so a new
    // word can be taken without a bubble.
    word_in_ready = (state == RUN) && (unfetched != '0) && (!buf_full || (half && out_load));
    word_accept   = word_in_valid && word_in_ready;
  end

  // Build the next beat from the current buffer half; lanes past the count are zeroed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    load_entries = '0;
    load_mask    = '0;
    n_lanes      = (unstaged >= CNT_W'(LANES)) ? 3'(LANES) : unstaged[2:0];
    half_data    = half ? word_buf[511:256] : word_buf[255:0];
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(n_lanes)) begin
        load_mask[LANES-1-k]  = 1'b1;
        load_entries[64*k +: 64] = half_data[64*k +: 64];
      end
    end
  end

  // Next-state logic for the pass controller.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (update_entry_count == '0) ? FIN : RUN;
      RUN:  if (out_fire && last_out) next_state = FIN;
      FIN:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Pass counters, word buffer, output register and completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unfetched       <= '0;
      unstaged        <= '0;
      // NOTE: the buffer payload is not reset; buf_full alone decides whether it holds data.
      buf_full        <= 1'b0;
      half            <= 1'b0;
      entry_out       <= '0;
      entry_out_valid <= '0;
      last_out        <= 1'b0;
      done            <= 1'b0;
      consumed_count  <= '0;
    end else begin
      if (state == IDLE && start) begin
        unfetched      <= update_entry_count;
        unstaged       <= update_entry_count;
        consumed_count <= '0;
        done           <= 1'b0;
      end
      if (state != FIN && next_state == FIN) done <= 1'b1;

      if (out_fire) consumed_count <= consumed_count + CNT_W'($countones(entry_out_valid));

      if (word_accept) begin
        word_buf  <= word_in;
        buf_full  <= 1'b1;
        half      <= 1'b0;
        unfetched <= (unfetched >= CNT_W'(8)) ? unfetched - CNT_W'(8) : '0;
      end else if (out_load) begin
        if (!half && unstaged > CNT_W'(LANES)) half <= 1'b1;
        else                                   buf_full <= 1'b0;
      end

      if (out_load) begin
        entry_out       <= load_entries;
        entry_out_valid <= load_mask;
        last_out        <= (unstaged <= CNT_W'(LANES));
        unstaged        <= unstaged - CNT_W'(n_lanes);
      end else if (out_fire) begin
        entry_out       <= '0;
        entry_out_valid <= '0;
        last_out        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_update_unpacker.sv
// Table-driven bench for update_unpacker: each vector runs one pass and checks
// every handshaken beat against entries numbered 1,2,3,... in packing order.
module tb_update_unpacker;

  localparam int CNT_W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  update_entry_count;
  logic [511:0] word_in;
  logic         word_in_valid;
  logic         word_in_ready;
  logic [255:0] entry_out;
  logic [3:0]   entry_out_valid;
  logic         entry_out_ready;
  logic         last_out;
  logic         done;
  logic [31:0]  consumed_count;

  int n_checks = 0;
  int n_pass   = 0;

  update_unpacker #(.CNT_W(CNT_W), .LANES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .update_entry_count(update_entry_count),
    .word_in(word_in), .word_in_valid(word_in_valid), .word_in_ready(word_in_ready),
    .entry_out(entry_out), .entry_out_valid(entry_out_valid), .entry_out_ready(entry_out_ready),
    .last_out(last_out), .done(done), .consumed_count(consumed_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          count;
    logic [7:0]  rdy_pat;     // entry_out_ready for cycle c is rdy_pat[c % 8]
    int          exp_beats;
    logic [31:0] exp_masks;   // beat b mask at [31-4b -: 4]
    int          exp_words;
    bit          repulse;     // pulse start again during RUN
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [511:0] make_word(input int w);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = 64'(w*8 + i + 1);
    return r;
  endfunction

  function automatic logic [255:0] exp_beat(input int b, input logic [3:0] m);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (m[3-k]) r[64*k +: 64] = 64'(4*b + k + 1);
    return r;
  endfunction

  // Runs one pass; abort_after > 0 returns right after that many beats.
  task automatic run_pass(input vec_t v, input int abort_after);
    int           beats;
    int           widx;
    bit           got_done;
    bit           have_snap;
    logic [255:0] snap_e;
    logic [3:0]   snap_v;
    logic         snap_l;
    logic [3:0]   m;
    @(negedge clk);
    word_in_valid      = 1'b0;
    entry_out_ready    = 1'b0;
    start              = 1'b1;
    update_entry_count = 32'(v.count);
    @(negedge clk);
    start     = 1'b0;
    beats     = 0;
    widx      = 0;
    got_done  = 1'b0;
    have_snap = 1'b0;
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      start = v.repulse && (cyc == 1);
      if (start) update_entry_count = 32'd99;
      entry_out_ready = v.rdy_pat[cyc % 8];
      word_in_valid   = 1'b1;
      word_in         = make_word(widx);
      #1;
      if (have_snap) begin
        check("stall_entry", entry_out, snap_e);
        check("stall_valid", 256'(entry_out_valid), 256'(snap_v));
        check("stall_last", 256'(last_out), 256'(snap_l));
        have_snap = 1'b0;
      end
      if (word_in_valid && word_in_ready) widx++;
      if (done) got_done = 1'b1;
      else if (entry_out_valid != 4'b0000) begin
        if (entry_out_ready) begin
          m = (beats < 8) ? v.exp_masks[31-4*beats -: 4] : 4'b0000;
          check($sformatf("mask_b%0d", beats), 256'(entry_out_valid), 256'(m));
          check($sformatf("data_b%0d", beats), entry_out, exp_beat(beats, m));
          check($sformatf("last_b%0d", beats), 256'(last_out), 256'(beats == v.exp_beats - 1));
          beats++;
        end else begin
          snap_e = entry_out; snap_v = entry_out_valid; snap_l = last_out;
          have_snap = 1'b1;
        end
      end
      if (abort_after > 0 && beats == abort_after) return;
      if (!got_done) @(negedge clk);
    end
    check("done_reached", 256'(got_done), 256'(1));
    check("beat_count", 256'(beats), 256'(v.exp_beats));
    check("consumed", 256'(consumed_count), 256'(v.count));
    check("words_taken", 256'(widx), 256'(v.exp_words));
    check("idle_valid", 256'(entry_out_valid), 256'(0));
  endtask

  initial begin
    vecs[0] = '{16, 8'hFF, 4, 32'hFFFF_0000, 2, 1'b0};
    vecs[1] = '{11, 8'hFF, 3, 32'hFFE0_0000, 2, 1'b0};
    vecs[2] = '{0,  8'hFF, 0, 32'h0000_0000, 0, 1'b0};
    vecs[3] = '{13, 8'h99, 4, 32'hFFF8_0000, 2, 1'b0};
    vecs[4] = '{5,  8'hFF, 2, 32'hF800_0000, 1, 1'b1};
    vecs[5] = '{4,  8'h55, 1, 32'hF000_0000, 1, 1'b0};
    vecs[6] = '{8,  8'hFF, 2, 32'hFF00_0000, 1, 1'b0};

    rst = 1'b1; start = 1'b0; update_entry_count = '0;
    word_in = '0; word_in_valid = 1'b0; entry_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 256'(entry_out_valid), 256'(0));
    check("rst_ready", 256'(word_in_ready), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_consumed", 256'(consumed_count), 256'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_pass(vecs[i], 0);

    // Asynchronous reset one beat into a 16-entry pass, then a fresh 8-entry pass.
    run_pass(vecs[0], 1);
    rst = 1'b1;
    #1;
    check("arst_entry", entry_out, 256'(0));
    check("arst_valid", 256'(entry_out_valid), 256'(0));
    check("arst_last", 256'(last_out), 256'(0));
    check("arst_consumed", 256'(consumed_count), 256'(0));
    check("arst_ready", 256'(word_in_ready), 256'(0));
    check("arst_done", 256'(done), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    run_pass(vecs[6], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
